// File: rtl/text_cursor_ctrl.sv
// Write-side sequencer for the VGA text tile buffer: turns received ASCII into
// character-RAM writes, tracks the cursor and runs full-screen / single-line clears.
module text_cursor_ctrl #(
    parameter int         COLS   = 80,
    parameter int         ROWS   = 30,
    parameter int         ADDR_W = 12,
    parameter logic [6:0] BLANK  = 7'h20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              new_data,
    input  logic [6:0]        data_in,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [6:0]        wdata,
    output logic [6:0]        cur_col,
    output logic [4:0]        cur_row,
    output logic              busy,
    output logic              overflow
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_EXEC     = 2'd1;
    localparam logic [1:0] S_CLR_ALL  = 2'd2;
    localparam logic [1:0] S_CLR_LINE = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_COL_A = ADDR_W'(COLS - 1);
    localparam logic [6:0]        LAST_COL   = 7'(COLS - 1);
    localparam logic [4:0]        LAST_ROW   = 5'(ROWS - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [6:0]        col_q, col_d;
    logic [4:0]        row_q, row_d;
    logic              hold_full_q, hold_full_d;
    logic [6:0]        hold_data_q, hold_data_d;
    logic [6:0]        code_q, code_d;
    logic              overflow_q, overflow_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [6:0]        wdata_q, wdata_d;

    logic              consume;
    logic              adv_row;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] col_a;

    // Full-width address math so row*COLS+col never truncates
    assign row_base = ADDR_W'(row_q) * ADDR_W'(COLS);
    assign col_a    = ADDR_W'(col_q);
    assign consume  = (state_q == S_IDLE) && hold_full_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        col_d       = col_q;
        row_d       = row_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        code_d      = code_q;
        overflow_d  = overflow_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        adv_row     = 1'b0;

        // A strobe into a full, unconsumed hold register is lost
        if (new_data) begin
            if (hold_full_q && !consume) begin
                overflow_d = 1'b1;
            end else begin
                hold_data_d = data_in;
                hold_full_d = 1'b1;
            end
        end else if (consume) begin
            hold_full_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (hold_full_q) begin
                    code_d  = hold_data_q;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_IDLE;
                if (code_q >= 7'h20 && code_q <= 7'h7E) begin
                    we_d    = 1'b1;
                    waddr_d = row_base + col_a;
                    wdata_d = code_q;
                    if (col_q < LAST_COL) begin
                        col_d = col_q + 7'd1;
                    end else begin
                        col_d   = 7'd0;
                        adv_row = 1'b1;
                    end
                end else begin
                    case (code_q)
                        7'h0A: begin
                            col_d   = 7'd0;
                            adv_row = 1'b1;
                        end
                        7'h0D: col_d = 7'd0;
                        7'h08: begin
                            if (col_q != 7'd0) begin
                                col_d   = col_q - 7'd1;
                                we_d    = 1'b1;
                                waddr_d = row_base + col_a - ADDR_W'(1);
                                wdata_d = BLANK;
                            end
                        end
                        7'h0C: begin
                            col_d   = 7'd0;
                            row_d   = 5'd0;
                            cnt_d   = '0;
                            state_d = S_CLR_ALL;
                        end
                        default: ;
                    endcase
                end
                // No scrolling: the last row wraps to the top and is wiped
                if (adv_row) begin
                    row_d   = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
                    cnt_d   = '0;
                    state_d = S_CLR_LINE;
                end
            end
            S_CLR_ALL: begin
                we_d    = 1'b1;
                waddr_d = cnt_q;
                wdata_d = BLANK;
                if (cnt_q == LAST_CELL) begin
                    cnt_d   = '0;
                    col_d   = 7'd0;
                    row_d   = 5'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                we_d    = 1'b1;
                waddr_d = row_base + cnt_q;
                wdata_d = BLANK;
                if (cnt_q == LAST_COL_A) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
        endcase
    end

    // Reset lands in CLR_ALL so the screen is wiped before any character is accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_CLR_ALL;
            cnt_q       <= '0;
            col_q       <= 7'd0;
            row_q       <= 5'd0;
            hold_full_q <= 1'b0;
            hold_data_q <= 7'd0;
            code_q      <= 7'd0;
            overflow_q  <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= BLANK;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            row_q       <= row_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            code_q      <= code_d;
            overflow_q  <= overflow_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign cur_col  = col_q;
    assign cur_row  = row_q;
    assign overflow = overflow_q;
    assign busy     = (state_q == S_CLR_ALL) || (state_q == S_CLR_LINE);

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Self-checking bench for text_cursor_ctrl: expected RAM writes are queued as
// stimulus is sent and checked in order by a write monitor; cursor checked after each step.
module tb_text_cursor_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        new_data;
    logic [6:0]  data_in;
    logic        we;
    logic [11:0] waddr;
    logic [6:0]  wdata;
    logic [6:0]  cur_col;
    logic [4:0]  cur_row;
    logic        busy;
    logic        overflow;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int         addr;
        logic [6:0] wd;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic [6:0] ch;
        bit         wr;
        int         addr;
        logic [6:0] wd;
        int         sweep_row;
        int         col;
        int         row;
    } vec_t;
    vec_t vec[12];

    text_cursor_ctrl #(.COLS(80), .ROWS(30), .ADDR_W(12), .BLANK(7'h20)) dut (
        .clk      (clk),
        .reset    (reset),
        .new_data (new_data),
        .data_in  (data_in),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .cur_col  (cur_col),
        .cur_row  (cur_row),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Every write the DUT makes must match the head of the expected queue
    always @(negedge clk) begin
        if (reset === 1'b1 && we === 1'b1) begin
            wr_t e;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", waddr, wdata);
            end else begin
                e = exp_q.pop_front();
                if (waddr !== 12'(e.addr) || wdata !== e.wd) begin
                    fails++;
                    $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                             waddr, wdata, e.addr, e.wd);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push_wr(input int a, input logic [6:0] d);
        wr_t e;
        e.addr = a;
        e.wd   = d;
        exp_q.push_back(e);
    endtask

    task automatic push_sweep(input int base, input int n);
        for (int i = 0; i < n; i++) push_wr(base + i, 7'h20);
    endtask

    task automatic send(input logic [6:0] c);
        @(negedge clk);
        new_data = 1'b1;
        data_in  = c;
        @(negedge clk);
        new_data = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        repeat (4) @(posedge clk);
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (n >= budget || exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d writes outstanding after %0d cycles, required 0", exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    task automatic chk_cursor(input string name, input int c, input int r);
        chk({name, "_col"}, 32'(cur_col), 32'(c));
        chk({name, "_row"}, 32'(cur_row), 32'(r));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0]  = '{7'h0D, 1'b0, 0,  7'h00, -1, 0, 0};
        vec[1]  = '{7'h78, 1'b1, 0,  7'h78, -1, 1, 0};
        vec[2]  = '{7'h7F, 1'b0, 0,  7'h00, -1, 1, 0};
        vec[3]  = '{7'h01, 1'b0, 0,  7'h00, -1, 1, 0};
        vec[4]  = '{7'h08, 1'b1, 0,  7'h20, -1, 0, 0};
        vec[5]  = '{7'h08, 1'b0, 0,  7'h00, -1, 0, 0};
        vec[6]  = '{7'h7E, 1'b1, 0,  7'h7E, -1, 1, 0};
        vec[7]  = '{7'h20, 1'b1, 1,  7'h20, -1, 2, 0};
        vec[8]  = '{7'h0A, 1'b0, 0,  7'h00,  1, 0, 1};
        vec[9]  = '{7'h71, 1'b1, 80, 7'h71, -1, 1, 1};
        vec[10] = '{7'h0D, 1'b0, 0,  7'h00, -1, 0, 1};
        vec[11] = '{7'h1B, 1'b0, 0,  7'h00, -1, 0, 1};

        reset    = 1'b0;
        new_data = 1'b0;
        data_in  = 7'h00;
        repeat (3) @(negedge clk);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'h20);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk_cursor("rst", 0, 0);

        // power-up clear
        push_sweep(0, 2400);
        reset = 1'b1;
        drain(3000);
        chk("init_busy", 32'(busy), 32'd0);
        chk_cursor("init", 0, 0);

        // 'A': write visible exactly two edges after the strobe edge
        push_wr(0, 7'h41);
        @(negedge clk);
        new_data = 1'b1;
        data_in  = 7'h41;
        @(negedge clk);
        new_data = 1'b0;
        chk("lat_n0", 32'(we), 32'd0);
        @(negedge clk);
        chk("lat_n1", 32'(we), 32'd0);
        @(negedge clk);
        chk("lat_n2", 32'(we), 32'd1);
        drain(100);
        chk_cursor("a", 1, 0);

        for (int i = 0; i < 12; i++) begin
            if (vec[i].wr) push_wr(vec[i].addr, vec[i].wd);
            if (vec[i].sweep_row >= 0) push_sweep(vec[i].sweep_row * 80, 80);
            send(vec[i].ch);
            drain(200);
            chk_cursor($sformatf("vec%0d", i), vec[i].col, vec[i].row);
        end

        // form feed back to (0,0), then 80 chars at full rate and one more
        push_sweep(0, 2400);
        send(7'h0C);
        drain(3000);
        chk_cursor("ff", 0, 0);
        for (int i = 0; i < 80; i++) begin
            push_wr(i, 7'(8'h30 + (i % 64)));
            if (i == 79) push_sweep(80, 80);
            send(7'(8'h30 + (i % 64)));
        end
        drain(300);
        chk_cursor("row_wrap", 0, 1);
        push_wr(80, 7'h5A);
        send(7'h5A);
        drain(100);
        chk_cursor("c81", 1, 1);
        chk("c81_overflow", 32'(overflow), 32'd0);

        // walk to row 29 col 5, then LF wraps to row 0
        for (int r = 2; r < 30; r++) begin
            push_sweep(r * 80, 80);
            send(7'h0A);
            drain(300);
        end
        for (int i = 0; i < 5; i++) begin
            push_wr(2320 + i, 7'(8'h61 + i));
            send(7'(8'h61 + i));
        end
        drain(100);
        chk_cursor("r29", 5, 29);
        push_sweep(0, 80);
        send(7'h0A);
        drain(300);
        chk_cursor("lf_wrap", 0, 0);
        send(7'h08);
        drain(100);
        chk_cursor("bs_col0", 0, 0);
        push_wr(0, 7'h42);
        send(7'h42);
        push_wr(0, 7'h20);
        send(7'h08);
        drain(100);
        chk_cursor("b_bs", 0, 0);

        // two chars during a sweep: one held, one dropped
        push_sweep(0, 2400);
        send(7'h0C);
        repeat (3) @(negedge clk);
        chk("ff_busy", 32'(busy), 32'd1);
        push_wr(0, 7'h43);
        send(7'h43);
        chk("ovf_before", 32'(overflow), 32'd0);
        send(7'h44);
        chk("ovf_set", 32'(overflow), 32'd1);
        drain(3000);
        chk_cursor("held", 1, 0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // reset in the middle of a full clear
        push_sweep(0, 1001);
        send(7'h0C);
        begin
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 2000) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("mid_reached", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        reset = 1'b0;
        #1;
        chk("mid_we", 32'(we), 32'd0);
        chk("mid_overflow", 32'(overflow), 32'd0);
        chk("mid_waddr", 32'(waddr), 32'd0);
        chk("mid_busy", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        push_sweep(0, 2400);
        reset = 1'b1;
        drain(3000);
        chk("post_busy", 32'(busy), 32'd0);
        chk_cursor("post", 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/text_cursor_ctrl.md
Name: text_cursor_ctrl

Overview:
- Write-side sequencer for the VGA text tile buffer.
- Consumes 7-bit ASCII characters from the UART receive path (data_in plus a new_data strobe) and tracks a cursor (col,row).
- Interprets control codes and issues single-cycle writes into the character RAM that the text screen generator reads for display.
- Runs multi-cycle clear sweeps (full screen, single line); buffers one pending character while a sweep is in progress.

Parameters:
- COLS, 80, characters per row (640/8).
- ROWS, 30, character rows (480/16).
- ADDR_W, 12, RAM address width; must satisfy 2^ADDR_W >= COLS*ROWS.
- BLANK, 7'h20, fill character used by clears and backspace.

Ports:
- clk  input  1  system clock (100 MHz).
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- new_data  input  1  one-cycle strobe: data_in valid.
- data_in  input  7  received ASCII code.
- we  output  1  RAM write enable, one cycle per cell written.
- waddr  output  ADDR_W  RAM address = row*COLS + col.
- wdata  output  7  RAM write data.
- cur_col  output  7  cursor column, 0..COLS-1.
- cur_row  output  5  cursor row, 0..ROWS-1.
- busy  output  1  high while a clear sweep runs.
- overflow  output  1  sticky: a character was dropped.

Behaviour:
- Reset (reset=0, async): we=0, waddr=0, wdata=BLANK, cur_col=0, cur_row=0, overflow=0, hold register empty, state=CLR_ALL with sweep counter 0, busy=1. Any sweep in progress is aborted immediately.
- After reset release, the block performs the CLR_ALL power-up clear before accepting characters.
- Hold register (1 deep):
  - new_data=1 at an edge loads data_in.
  - If hold is already full and not consumed at that edge, the character is dropped and overflow is set (cleared only by reset).
  - Consume and load at the same edge: the new character is kept, no overflow.
- States: IDLE, EXEC, CLR_ALL, CLR_LINE.
- IDLE:
  - If hold is full: consume it, latch the code, go to EXEC.
  - Otherwise we=0.
- EXEC (one cycle; all outputs registered, so we, waddr and wdata appear the cycle after the EXEC decision). Handling by code:
  - 0x20..0x7E: write the code at (col,row), then advance. col<COLS-1 gives col+1. Otherwise col=0 and the row advances.
  - 0x0A (LF): col=0, row advances. No write.
  - 0x0D (CR): col=0. No write.
  - 0x08 (BS): if col>0, col-1 and write BLANK at the new position. If col=0, no-op (no reverse line wrap).
  - 0x0C (FF): go to CLR_ALL; cursor is set to (0,0).
  - All other codes (0x00..0x1F except the above, and 0x7F): ignored, no write.
- Row advance:
  - row<ROWS-1 gives row+1, and the new row is cleared via CLR_LINE.
  - row=ROWS-1 wraps to row 0, and row 0 is cleared via CLR_LINE.
  - There is no scrolling.
- Return from EXEC: to IDLE unless a sweep was entered.
- CLR_ALL:
  - Writes BLANK to addresses 0..COLS*ROWS-1 ascending, one per cycle: we=1 for COLS*ROWS consecutive cycles.
  - Then goes to IDLE with cursor (0,0).
- CLR_LINE:
  - Writes BLANK at row*COLS+0 .. row*COLS+COLS-1, one per cycle: COLS consecutive we=1 cycles.
  - The cursor already holds the new position.
  - Then goes to IDLE.
- busy=1 in CLR_ALL and CLR_LINE, 0 otherwise.
- new_data arriving during a sweep goes to hold and is processed on return to IDLE.
- Latency, idle case: new_data sampled at edge N gives hold full; EXEC at edge N+1; we=1 during the cycle after edge N+2. Sustained throughput is 1 character per 2 cycles when no sweep occurs.
- Arithmetic: waddr is computed at ADDR_W bits with no truncation. Maximum address is COLS*ROWS-1 = 2399.

Test Plan:
- Release reset, no input -> busy=1; exactly 2400 we pulses with wdata=0x20 at waddr 0..2399 in order; then busy=0, cursor (0,0).
- After init, send 'A' (0x41) -> single we, waddr=0, wdata=0x41, 2 cycles after the strobe edge; cursor (1,0).
- Send 81 printable chars from (0,0) -> the 80th char lands at waddr 79; row advance triggers 80 BLANK writes at 80..159; the 81st char lands at waddr 80; cursor (1,1).
- Cursor at (5,29), send 0x0A -> cursor (0,0); 80 BLANK writes at 0..79. Then send 0x08 at col 0 -> no write. Then send 'B','\b' -> writes 0x42 then 0x20 at waddr 0; cursor (0,0).
- Send 0x0C, then two chars during the sweep -> first is held and written after busy falls; second is dropped; overflow=1.
- Assert reset mid CLR_ALL (e.g. at address 1000) -> we=0 immediately, overflow=0; after release the sweep restarts from address 0.
